// File: rtl/sram_bus_arbiter.sv
// Two-master round-robin arbiter in front of a single SRAM controller bus.
// One access in flight at a time; a timeout turns a missing downstream acknowledge into an error response.
module sram_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [15:0] ERROR_DATA     = 16'h0000
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        m0_request,
  input  logic [18:0] m0_address,
  input  logic [1:0]  m0_byte_enable,
  input  logic        m0_rw,
  input  logic [15:0] m0_write_data,
  output logic        m0_acknowledge,
  output logic        m0_error,
  output logic [15:0] m0_read_data,
  input  logic        m1_request,
  input  logic [18:0] m1_address,
  input  logic [1:0]  m1_byte_enable,
  input  logic        m1_rw,
  input  logic [15:0] m1_write_data,
  output logic        m1_acknowledge,
  output logic        m1_error,
  output logic [15:0] m1_read_data,
  output logic        bus_enable,
  output logic [18:0] address,
  output logic [1:0]  byte_enable,
  output logic        rw,
  output logic [15:0] write_data,
  input  logic        acknowledge,
  input  logic [15:0] read_data,
  output logic [1:0]  grant,
  output logic        busy
);

  // state      | meaning
  // ST_IDLE    | no owner; requests sampled every edge
  // ST_ACCESS  | bus_enable high, waiting for controller acknowledge or timeout
  // ST_RESPOND | one-cycle acknowledge back to the owning master
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESPOND} state_t;

  localparam logic [7:0] TIMER_LOAD = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [7:0]  timer, timer_next;
  logic        last_grant, last_grant_next;
  logic        winner, resp_valid, resp_err;
  logic [15:0] resp_data;
  logic        bus_enable_next, rw_next, busy_next;
  logic [18:0] address_next;
  logic [1:0]  byte_enable_next, grant_next;
  logic [15:0] write_data_next, m0_rd_next, m1_rd_next;
  logic        m0_ack_next, m1_ack_next, m0_err_next, m1_err_next;

  // On contention the master that did not win last time gets the bus.
  assign winner = (m0_request && m1_request) ? ~last_grant : m1_request;

  always_comb begin
    state_next       = state;
    timer_next       = timer;
    last_grant_next  = last_grant;
    bus_enable_next  = bus_enable;
    address_next     = address;
    byte_enable_next = byte_enable;
    rw_next          = rw;
    write_data_next  = write_data;
    grant_next       = grant;
    busy_next        = busy;
    m0_ack_next      = 1'b0;
    m1_ack_next      = 1'b0;
    m0_err_next      = 1'b0;
    m1_err_next      = 1'b0;
    m0_rd_next       = m0_read_data;
    m1_rd_next       = m1_read_data;
    resp_valid       = 1'b0;
    resp_err         = 1'b0;
    resp_data        = 16'h0000;
    case (state)
      ST_IDLE: begin
        if (m0_request || m1_request) begin
          address_next     = winner ? m1_address     : m0_address;
          byte_enable_next = winner ? m1_byte_enable : m0_byte_enable;
          rw_next          = winner ? m1_rw          : m0_rw;
          write_data_next  = winner ? m1_write_data  : m0_write_data;
          grant_next       = winner ? 2'b10 : 2'b01;
          last_grant_next  = winner;
          bus_enable_next  = 1'b1;
          busy_next        = 1'b1;
          timer_next       = TIMER_LOAD;
          state_next       = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // acknowledge wins over a timeout landing on the same edge
        if (acknowledge) begin
          resp_valid = 1'b1;
          resp_data  = rw ? read_data : 16'h0000;
        end else if (timer == 8'd0) begin
          resp_valid = 1'b1;
          resp_err   = 1'b1;
          resp_data  = ERROR_DATA;
        end else begin
          timer_next = timer - 8'd1;
        end
        if (resp_valid) begin
          bus_enable_next = 1'b0;
          state_next      = ST_RESPOND;
          if (grant[1]) begin
            m1_ack_next = 1'b1;
            m1_err_next = resp_err;
            m1_rd_next  = resp_data;
          end else begin
            m0_ack_next = 1'b1;
            m0_err_next = resp_err;
            m0_rd_next  = resp_data;
          end
        end
      end
      ST_RESPOND: begin
        grant_next = 2'b00;
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state          <= ST_IDLE;
      timer          <= 8'd0;
      last_grant     <= 1'b1;
      bus_enable     <= 1'b0;
      address        <= '0;
      byte_enable    <= '0;
      rw             <= 1'b0;
      write_data     <= '0;
      grant          <= '0;
      busy           <= 1'b0;
      m0_acknowledge <= 1'b0;
      m1_acknowledge <= 1'b0;
      m0_error       <= 1'b0;
      m1_error       <= 1'b0;
      m0_read_data   <= '0;
      m1_read_data   <= '0;
    end else begin
      state          <= state_next;
      timer          <= timer_next;
      last_grant     <= last_grant_next;
      bus_enable     <= bus_enable_next;
      address        <= address_next;
      byte_enable    <= byte_enable_next;
      rw             <= rw_next;
      write_data     <= write_data_next;
      grant          <= grant_next;
      busy           <= busy_next;
      m0_acknowledge <= m0_ack_next;
      m1_acknowledge <= m1_ack_next;
      m0_error       <= m0_err_next;
      m1_error       <= m1_err_next;
      m0_read_data   <= m0_rd_next;
      m1_read_data   <= m1_rd_next;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of arbitration, latency and response.
module tb_sram_bus_arbiter;

  localparam int T = 16;
  localparam logic [15:0] ERR_DATA = 16'h0000;
  localparam int NEVER = 1000;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        m0_request, m0_rw, m0_acknowledge, m0_error;
  logic [18:0] m0_address;
  logic [1:0]  m0_byte_enable;
  logic [15:0] m0_write_data, m0_read_data;
  logic        m1_request, m1_rw, m1_acknowledge, m1_error;
  logic [18:0] m1_address;
  logic [1:0]  m1_byte_enable;
  logic [15:0] m1_write_data, m1_read_data;
  logic        bus_enable, rw, acknowledge, busy;
  logic [18:0] address;
  logic [1:0]  byte_enable, grant;
  logic [15:0] write_data, read_data;

  int          checks = 0;
  int          errors = 0;
  int          be_cnt = 0;
  int          ack_delay = 0;
  logic [15:0] ctrl_data = 16'h0000;
  int          exp_last = 1;

  sram_bus_arbiter #(.TIMEOUT_CYCLES(T), .ERROR_DATA(ERR_DATA)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .m0_request(m0_request), .m0_address(m0_address), .m0_byte_enable(m0_byte_enable),
    .m0_rw(m0_rw), .m0_write_data(m0_write_data), .m0_acknowledge(m0_acknowledge),
    .m0_error(m0_error), .m0_read_data(m0_read_data),
    .m1_request(m1_request), .m1_address(m1_address), .m1_byte_enable(m1_byte_enable),
    .m1_rw(m1_rw), .m1_write_data(m1_write_data), .m1_acknowledge(m1_acknowledge),
    .m1_error(m1_error), .m1_read_data(m1_read_data),
    .bus_enable(bus_enable), .address(address), .byte_enable(byte_enable), .rw(rw),
    .write_data(write_data), .acknowledge(acknowledge), .read_data(read_data),
    .grant(grant), .busy(busy)
  );

  always #5 clk_clk = ~clk_clk;

  // Controller model: acknowledges combinationally once bus_enable has been high ack_delay cycles.
  always @(posedge clk_clk) be_cnt <= bus_enable ? be_cnt + 1 : 0;
  assign acknowledge = bus_enable && (be_cnt == ack_delay);
  assign read_data   = ctrl_data;

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic randomize_fields();
    m0_address = 19'($urandom); m0_byte_enable = 2'($urandom); m0_rw = 1'($urandom);
    m0_write_data = 16'($urandom);
    m1_address = 19'($urandom); m1_byte_enable = 2'($urandom); m1_rw = 1'($urandom);
    m1_write_data = 16'($urandom);
  endtask

  // One complete access from the IDLE cycle: predict owner, latched fields,
  // number of bus cycles and the response, then return to IDLE.
  task automatic txn(input bit q0, input bit q1, input int dly, input logic [15:0] data);
    int          win, cnt, exp_cnt;
    bit          tmo, stable;
    logic [18:0] ea;
    logic [1:0]  eb, eg;
    logic        er;
    logic [15:0] ew, ed;
    ack_delay  = dly;
    ctrl_data  = data;
    m0_request = q0;
    m1_request = q1;
    win = (q0 && q1) ? 1 - exp_last : (q1 ? 1 : 0);
    exp_last = win;
    ea = win ? m1_address : m0_address;
    eb = win ? m1_byte_enable : m0_byte_enable;
    er = win ? m1_rw : m0_rw;
    ew = win ? m1_write_data : m0_write_data;
    eg = win ? 2'b10 : 2'b01;
    tmo = (dly >= T);
    exp_cnt = tmo ? T : dly + 1;
    ed = tmo ? ERR_DATA : (er ? data : 16'h0000);
    step();
    chk("grant", 32'(grant), 32'(eg));
    chk("bus_enable", 32'(bus_enable), 32'd1);
    chk("busy", 32'(busy), 32'd1);
    chk("address", 32'(address), 32'(ea));
    chk("byte_enable", 32'(byte_enable), 32'(eb));
    chk("rw", 32'(rw), 32'(er));
    if (!er) chk("write_data", 32'(write_data), 32'(ew));
    randomize_fields();
    cnt = 0;
    stable = 1'b1;
    while (bus_enable === 1'b1 && cnt < 300) begin
      stable = stable && (address === ea) && (rw === er) && (byte_enable === eb)
               && (write_data === ew) && (grant === eg) && (busy === 1'b1);
      cnt++;
      step();
    end
    chk("held", 32'(stable), 32'd1);
    chk("access_cycles", 32'(cnt), 32'(exp_cnt));
    chk("ack_owner", 32'({m1_acknowledge, m0_acknowledge}), 32'(eg));
    chk("error", 32'(win ? m1_error : m0_error), 32'(tmo));
    chk("read_data", 32'(win ? m1_read_data : m0_read_data), 32'(ed));
    chk("other_err", 32'(win ? m0_error : m1_error), 32'd0);
    m0_request = 1'b0;
    m1_request = 1'b0;
    step();
    chk("idle_grant", 32'(grant), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ack", 32'({m1_acknowledge, m0_acknowledge}), 32'd0);
  endtask

  initial begin
    int n_ack, n_grant, prev_c;
    logic [1:0] prev_g;
    reset_reset = 1'b1;
    m0_request = 1'b0; m1_request = 1'b0;
    randomize_fields();
    step(); step();
    chk("rst_bus_enable", 32'(bus_enable), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acks", 32'({m1_acknowledge, m0_acknowledge, m1_error, m0_error}), 32'd0);
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_write_data", 32'(write_data), 32'd0);
    chk("rst_read_data", {m1_read_data, m0_read_data}, 32'd0);
    reset_reset = 1'b0;
    step();

    // contention from reset: strict alternation, m0 first, 3-cycle turnaround
    ack_delay = 0;
    m0_request = 1'b1; m1_request = 1'b1;
    n_ack = 0; n_grant = 0; prev_c = 0; prev_g = 2'b00;
    for (int c = 0; c < 60 && n_ack < 6; c++) begin
      step();
      if (grant !== 2'b00 && prev_g === 2'b00) begin
        chk("cont_grant", 32'(grant), (n_grant % 2) ? 32'd2 : 32'd1);
        n_grant++;
      end
      prev_g = grant;
      if (m0_acknowledge === 1'b1 || m1_acknowledge === 1'b1) begin
        chk("cont_ack", 32'({m1_acknowledge, m0_acknowledge}), (n_ack % 2) ? 32'd2 : 32'd1);
        if (n_ack > 0) chk("cont_gap", 32'(c - prev_c), 32'd3);
        prev_c = c;
        n_ack++;
        if (n_ack == 6) begin
          m0_request = 1'b0; m1_request = 1'b0;
        end
      end
    end
    chk("cont_acks", 32'(n_ack), 32'd6);
    chk("cont_grants", 32'(n_grant), 32'd6);
    step(); step();
    chk("cont_idle", 32'(grant), 32'd0);
    exp_last = 1;

    // single read by m0
    m0_address = 19'h00010; m0_rw = 1'b1; m0_byte_enable = 2'b11;
    txn(1'b1, 1'b0, 0, 16'hBEEF);
    // single write by m1
    m1_address = 19'h00ABC; m1_rw = 1'b0; m1_byte_enable = 2'b01; m1_write_data = 16'h1234;
    txn(1'b0, 1'b1, 0, 16'h7777);
    // timeout, then a normal m1 access
    m0_address = 19'h12345; m0_rw = 1'b1;
    txn(1'b1, 1'b0, NEVER, 16'hAAAA);
    m1_rw = 1'b1;
    txn(1'b0, 1'b1, 2, 16'h5A5A);
    // acknowledge on the last cycle before the timeout would fire
    m0_rw = 1'b1;
    txn(1'b1, 1'b0, T - 1, 16'hC0DE);

    // reset during ACCESS
    ack_delay = NEVER;
    m0_request = 1'b1;
    step();
    m0_request = 1'b0;
    chk("mid_bus_enable_pre", 32'(bus_enable), 32'd1);
    step(); step();
    #1 reset_reset = 1'b1;
    #1;
    chk("mid_bus_enable", 32'(bus_enable), 32'd0);
    chk("mid_grant", 32'(grant), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    step(); step();
    chk("mid_no_ack", 32'({m1_acknowledge, m0_acknowledge}), 32'd0);
    reset_reset = 1'b0;
    exp_last = 1;
    randomize_fields();
    txn(1'b1, 1'b1, 0, 16'h0F0F);

    // late deassert: m0 keeps requesting through the IDLE cycle
    ack_delay = 0;
    m0_address = 19'h0BEEF; m0_rw = 1'b1;
    m0_request = 1'b1;
    step();
    chk("late_grant1", 32'(grant), 32'd1);
    step();
    chk("late_ack1", 32'(m0_acknowledge), 32'd1);
    step();
    chk("late_idle", 32'(grant), 32'd0);
    step();
    chk("late_grant2", 32'(grant), 32'd1);
    chk("late_addr2", 32'(address), 32'h0BEEF);
    m0_request = 1'b0;
    step();
    chk("late_ack2", 32'(m0_acknowledge), 32'd1);
    step();
    chk("late_done", 32'(grant), 32'd0);
    exp_last = 0;

    // randomized transactions
    for (int i = 0; i < 30; i++) begin
      int pat, dly;
      pat = $urandom_range(1, 3);
      dly = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 4);
      randomize_fields();
      txn(pat[0], pat[1], dly, 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
